// File: rtl/nco_hop_if.sv
// Hop-scheduler bus: table config, sequence control, NCO handshake and status.
interface nco_hop_if #(
  parameter int unsigned APR = 32,
  parameter int unsigned AW  = 3,
  parameter int unsigned DWW = 16
);
  logic           cfg_we;
  logic [AW-1:0]  cfg_addr;
  logic [APR-1:0] cfg_data;
  logic [DWW-1:0] dwell;
  logic [AW-1:0]  last_idx;
  logic           start;
  logic           stop;
  logic           nco_valid;
  logic [APR-1:0] phi_inc_o;
  logic           nco_clken_o;
  logic           tone_valid;
  logic [AW-1:0]  hop_idx;
  logic           busy;
  logic           done;

  modport master (
    output cfg_we, cfg_addr, cfg_data, dwell, last_idx, start, stop, nco_valid,
    input  phi_inc_o, nco_clken_o, tone_valid, hop_idx, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, dwell, last_idx, start, stop, nco_valid,
    output phi_inc_o, nco_clken_o, tone_valid, hop_idx, busy, done
  );
endinterface

// File: rtl/nco_hop_sched.sv
// Frequency-hop scheduler: steps an NCO through a phase-increment table with settle/dwell timing.
// Optional NCO_HOP_LOOP_EN: wrap to entry 0 after the last hop instead of returning to idle.
module nco_hop_sched #(
  parameter int unsigned APR = 32,
  parameter int unsigned AW  = 3,
  parameter int unsigned DWW = 16,
  parameter int unsigned LAT = 12
) (
  input logic     clk,
  input logic     reset,
  nco_hop_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned SW    = $clog2(LAT + 1);
  localparam int unsigned CW    = (DWW > SW) ? DWW : SW;

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  hop_q, hop_d, last_q, last_d;
  logic [DWW-1:0] dwell_q, dwell_d, dwell_eff;
  logic [APR-1:0] phi_q, phi_d;
  logic           done_q, done_d;
  logic           clken_q, tone_q, busy_q;
  logic           settle_exp, run_end;
  logic [APR-1:0] tbl [DEPTH];

  // Table is config-only storage: no reset, writes locked out while sequencing
  always_ff @(posedge clk) begin
    if (bus.cfg_we && !busy_q) tbl[bus.cfg_addr] <= bus.cfg_data;
  end

  assign dwell_eff  = (dwell_q == '0) ? DWW'(1) : dwell_q;
  assign settle_exp = (cnt_q >= CW'(LAT - 1));
  assign run_end    = (cnt_q == CW'(dwell_eff - DWW'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hop_d   = hop_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    phi_d   = phi_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = SETTLE;
          cnt_d   = '0;
          hop_d   = '0;
          phi_d   = tbl[AW'(0)];
          dwell_d = bus.dwell;
          last_d  = bus.last_idx;
        end
      end
      SETTLE: begin
        // Settle counter saturates at expiry and then waits on nco_valid
        if (bus.stop) begin
          state_d = IDLE;
        end else if (settle_exp && bus.nco_valid) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (!settle_exp) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (run_end) begin
          cnt_d = '0;
          if (hop_q != last_q) begin
            state_d = SETTLE;
            hop_d   = hop_q + AW'(1);
            phi_d   = tbl[hop_q + AW'(1)];
          end else begin
            done_d = 1'b1;
`ifdef NCO_HOP_LOOP_EN
            state_d = SETTLE;
            hop_d   = '0;
            phi_d   = tbl[AW'(0)];
`else
            state_d = IDLE;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track state_q exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hop_q   <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      phi_q   <= '0;
      done_q  <= 1'b0;
      clken_q <= 1'b0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hop_q   <= hop_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      phi_q   <= phi_d;
      done_q  <= done_d;
      clken_q <= (state_d != IDLE);
      tone_q  <= (state_d == RUN);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.phi_inc_o   = phi_q;
  assign bus.nco_clken_o = clken_q;
  assign bus.tone_valid  = tone_q;
  assign bus.hop_idx     = hop_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_nco_hop_sched.sv
// Bench for nco_hop_sched: per-cycle trace predicted from hop timing rules, randomized scenarios.
module tb_nco_hop_sched;
  localparam int unsigned APR  = 32;
  localparam int unsigned AW   = 3;
  localparam int unsigned DWW  = 16;
  localparam int unsigned LAT  = 12;
  localparam int          D    = 8;
  localparam int          MAXC = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nco_hop_if #(.APR(APR), .AW(AW), .DWW(DWW)) bus ();

  nco_hop_sched #(.APR(APR), .AW(AW), .DWW(DWW), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [APR-1:0] tbl_m [D];
  bit             nv    [MAXC];
  int             e_st  [MAXC];   // 0 idle, 1 settle, 2 run
  int             e_hop [MAXC];
  logic [APR-1:0] e_phi [MAXC];
  bit             e_done[MAXC];
  int             held_hop = 0;
  logic [APR-1:0] held_phi = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_tbl(input int a, input logic [APR-1:0] dat);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AW'(a);
    bus.cfg_data = dat;
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
    tbl_m[a]     = dat;
  endtask

  function automatic void fill_nv(input int mode);
    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        0:       nv[c] = 1'b1;
        1:       nv[c] = (c >= 20);
        default: nv[c] = ($urandom_range(0, 9) < 6);
      endcase
    end
  endfunction

  // Timeline from start in cycle 0: each hop settles >= LAT cycles until nco_valid, then dwells
  function automatic void build(input int d, input int last, input int stop_at);
    int de, t, h, k;
    bit pd, fin;
    de = (d == 0) ? 1 : d;
    for (int c = 0; c < MAXC; c++) begin
      e_st[c] = 0; e_hop[c] = held_hop; e_phi[c] = held_phi; e_done[c] = 1'b0;
    end
    if (stop_at == 0) return;
    t = 1; h = 0; pd = 1'b0; fin = 1'b0;
    while (!fin && t < MAXC) begin
      k = t + int'(LAT) - 1;
      while (k < MAXC && !nv[k]) k++;
      for (int c = t; c < MAXC; c++) begin
        e_hop[c] = h; e_phi[c] = tbl_m[h];
      end
      for (int c = t; c <= k && c < MAXC; c++) e_st[c] = 1;
      e_done[t] = pd;
      for (int c = k + 1; c <= k + de && c < MAXC; c++) e_st[c] = 2;
      t = k + de + 1;
      if (h == last) begin
        pd = 1'b1;
`ifdef NCO_HOP_LOOP_EN
        h = 0;
`else
        if (t < MAXC) e_done[t] = 1'b1;
        fin = 1'b1;
`endif
      end else begin
        h++;
        pd = 1'b0;
      end
    end
    if (stop_at > 0 && stop_at < MAXC && e_st[stop_at] != 0) begin
      for (int c = stop_at + 1; c < MAXC; c++) begin
        e_st[c] = 0; e_hop[c] = e_hop[stop_at]; e_phi[c] = e_phi[stop_at]; e_done[c] = 1'b0;
      end
    end
  endfunction

  // stop_at: -1 none, -2 first RUN cycle of hop 1, otherwise cycle index (0 = with start)
  task automatic run_seq(input int d, input int last, input int stop_at, input bit busy_wr);
    int sa, ncyc;
    sa = stop_at;
`ifdef NCO_HOP_LOOP_EN
    if (sa == -1) sa = 150;
`endif
    if (sa == -2) begin
      build(d, last, -1);
      sa = -1;
      for (int c = 0; c < MAXC; c++)
        if (sa < 0 && e_st[c] == 2 && e_hop[c] == 1) sa = c;
    end
    build(d, last, sa);
    ncyc = 0;
    for (int c = 0; c < MAXC; c++) if (e_st[c] != 0) ncyc = c;
    ncyc = (ncyc + 3 > MAXC) ? MAXC : ncyc + 3;
    bus.dwell    = DWW'(d);
    bus.last_idx = AW'(last);
    for (int c = 0; c < ncyc; c++) begin
      bus.start     = (c == 0);
      bus.stop      = (c == sa);
      bus.nco_valid = nv[c];
      if (c > 0) begin
        bus.dwell    = DWW'($urandom);
        bus.last_idx = AW'($urandom);
      end
      bus.cfg_we   = busy_wr && (e_st[c] != 0) && (c == 1 || $urandom_range(0, 3) == 0);
      bus.cfg_addr = (c == 1) ? AW'(0) : AW'($urandom);
      bus.cfg_data = APR'($urandom);
      @(negedge clk);
      check($sformatf("phi@%0d", c),   64'(bus.phi_inc_o),   64'(e_phi[c]));
      check($sformatf("hop@%0d", c),   64'(bus.hop_idx),     64'(e_hop[c]));
      check($sformatf("clken@%0d", c), 64'(bus.nco_clken_o), 64'(e_st[c] != 0));
      check($sformatf("busy@%0d", c),  64'(bus.busy),        64'(e_st[c] != 0));
      check($sformatf("tone@%0d", c),  64'(bus.tone_valid),  64'(e_st[c] == 2));
      check($sformatf("done@%0d", c),  64'(bus.done),        64'(e_done[c]));
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_we = 1'b0;
    held_hop = e_hop[ncyc-1];
    held_phi = e_phi[ncyc-1];
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_phi"},   64'(bus.phi_inc_o),   64'(0));
    check({pfx, "_hop"},   64'(bus.hop_idx),     64'(0));
    check({pfx, "_clken"}, 64'(bus.nco_clken_o), 64'(0));
    check({pfx, "_tone"},  64'(bus.tone_valid),  64'(0));
    check({pfx, "_busy"},  64'(bus.busy),        64'(0));
    check({pfx, "_done"},  64'(bus.done),        64'(0));
  endtask

  initial begin
    reset = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.dwell = '0; bus.last_idx = '0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.nco_valid = 1'b0;
    #8;
    check_zero("reset");
    #15 reset = 1'b0;
    @(posedge clk); #1;

    // Directed three-hop pass with immediate nco_valid
    write_tbl(0, 32'h0100_0000);
    write_tbl(1, 32'h0200_0000);
    write_tbl(2, 32'h0300_0000);
    fill_nv(0);
    run_seq(5, 2, -1, 1'b0);

    // nco_valid late: settle extends until it rises
    fill_nv(1);
    run_seq(5, 2, -1, 1'b0);

    // Stop during RUN of hop 1
    fill_nv(0);
    run_seq(5, 2, -2, 1'b0);

    // Writes while busy are dropped; next start still sees the original entries
    run_seq(4, 2, -1, 1'b1);
    run_seq(3, 1, -1, 1'b0);

    // Zero dwell, then start+stop together in idle
    run_seq(0, 2, -1, 1'b0);
    run_seq(5, 2, 0, 1'b0);

    // Two-entry sequence (wraps when looping is built in)
    run_seq(2, 1, -1, 1'b0);

    // Randomized tables, dwell, length, nco_valid, stop and busy writes
    for (int i = 0; i < 8; i++) begin
      for (int a = 0; a < D; a++) write_tbl(a, APR'($urandom));
      fill_nv(2);
      run_seq($urandom_range(0, 6), $urandom_range(0, 7),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 80) : -1,
              1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of RUN
    fill_nv(0);
    bus.dwell = DWW'(20); bus.last_idx = AW'(3); bus.nco_valid = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 100 && !bus.tone_valid; i++) begin
      @(posedge clk); #1;
    end
    check("reset_wait_run", 64'(bus.tone_valid), 64'(1));
    #2 reset = 1'b1;
    #1 check_zero("midrun_reset");
    @(negedge clk) reset = 1'b0;
    bus.nco_valid = 1'b0;
    @(posedge clk); #1;
    held_hop = 0; held_phi = '0;
    for (int a = 0; a < D; a++) write_tbl(a, APR'($urandom));
    fill_nv(2);
    run_seq(2, 3, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
